// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch FSM with synchronized, edge-detected buttons and optional lap capture.
// Ports: clk; hard_reset (async, active-low); btn_start_stop / btn_clear / btn_lap (raw levels);
//        sec_count_in (seconds counter value); en (00 reset, 01 count, 10 hold); lap_count/lap_valid
//        (captured lap); overflow (state is OVF); state (FSM encoding, debug).
// Optional feature: define STOPWATCH_LAP_EN to build the lap synchronizer and capture register;
//        otherwise btn_lap is ignored and lap_count/lap_valid are tied to 0.
module stopwatch_ctrl #(
  parameter int WIDTH       = 19,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 359999
) (
  input  logic             clk,
  input  logic             hard_reset,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic [WIDTH-1:0] sec_count_in,
  output logic [1:0]       en,
  output logic [WIDTH-1:0] lap_count,
  output logic             lap_valid,
  output logic             overflow,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {CLEAR = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVF = 2'b11} state_t;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  state_t st, next_state;
  logic [SYNC_STAGES-1:0] ss_sync, clr_sync;
  logic ss_prev, clr_prev, ss_pulse, clr_pulse;
  logic [1:0] en_d;
  logic ovf_d;
  always_ff @(posedge clk or negedge hard_reset)
    if (!hard_reset) begin
      ss_sync  <= '0;
      clr_sync <= '0;
      ss_prev  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], btn_start_stop};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], btn_clear};
      ss_prev  <= ss_sync[SYNC_STAGES-1];
      clr_prev <= clr_sync[SYNC_STAGES-1];
    end
  // one-cycle pulse on the first high synchronized sample; re-arms after a low sample
  assign ss_pulse  = ss_sync[SYNC_STAGES-1] & ~ss_prev;
  assign clr_pulse = clr_sync[SYNC_STAGES-1] & ~clr_prev;
  always_ff @(posedge clk or negedge hard_reset)
    if (!hard_reset) begin
      st       <= CLEAR;
      en       <= 2'b00;
      overflow <= 1'b0;
    end else begin
      st       <= next_state;
      en       <= en_d;
      overflow <= ovf_d;
    end
  always_comb begin
    next_state = st;
    case (st)
      CLEAR:   next_state = ss_pulse ? RUN : CLEAR;
      RUN:     next_state = (sec_count_in >= MAX_C) ? OVF : ss_pulse ? PAUSE : RUN;
      PAUSE:   next_state = clr_pulse ? CLEAR : ss_pulse ? RUN : PAUSE;
      default: next_state = clr_pulse ? CLEAR : OVF;
    endcase
  end
  // outputs are decoded from next_state so the registered copies track state on the same edge
  always_comb begin
    en_d  = next_state == CLEAR ? 2'b00 : next_state == RUN ? 2'b01 : 2'b10;
    ovf_d = next_state == OVF;
  end
  assign state = st;
`ifdef STOPWATCH_LAP_EN
  logic [SYNC_STAGES-1:0] lap_sync;
  logic lap_prev, lap_pulse;
  assign lap_pulse = lap_sync[SYNC_STAGES-1] & ~lap_prev;
  always_ff @(posedge clk or negedge hard_reset)
    if (!hard_reset) begin
      lap_sync  <= '0;
      lap_prev  <= 1'b0;
      lap_count <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_sync <= {lap_sync[SYNC_STAGES-2:0], btn_lap};
      lap_prev <= lap_sync[SYNC_STAGES-1];
      if (next_state == CLEAR && st != CLEAR) begin
        lap_count <= '0;
        lap_valid <= 1'b0;
      end else if (lap_pulse && st == RUN) begin
        lap_count <= sec_count_in;
        lap_valid <= 1'b1;
      end
    end
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_count  = '0;
  assign lap_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed test of stopwatch_ctrl against a per-edge behavioural model.
module tb_stopwatch_ctrl;
  localparam int W = 19;
  localparam int S = 2;
  localparam int MAXC = 359999;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic hard_reset = 1'b0;
  logic btn_start_stop = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic [W-1:0] sec_count_in = '0;
  logic [1:0] en, state;
  logic [W-1:0] lap_count;
  logic lap_valid, overflow;
  int tests = 0, fails = 0;
  stopwatch_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .hard_reset(hard_reset), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .sec_count_in(sec_count_in), .en(en), .lap_count(lap_count),
    .lap_valid(lap_valid), .overflow(overflow), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: 0 CLEAR, 1 RUN, 2 PAUSE, 3 OVF. A button counts at edge E when its raw sample
  // taken S edges earlier was high and the one before that was low.
  int m_st, nxt;
  int m_lap;
  bit m_lv, p_ss, p_clr, p_lap;
  bit [S:0] h_ss, h_clr, h_lap;
  always @(posedge clk or negedge hard_reset)
    if (!hard_reset) begin
      m_st = 0; m_lap = 0; m_lv = 0; h_ss = '0; h_clr = '0; h_lap = '0;
    end else begin
      p_ss  = h_ss[S-1] && !h_ss[S];
      p_clr = h_clr[S-1] && !h_clr[S];
      p_lap = h_lap[S-1] && !h_lap[S];
      h_ss  = {h_ss[S-1:0], btn_start_stop};
      h_clr = {h_clr[S-1:0], btn_clear};
      h_lap = {h_lap[S-1:0], btn_lap};
      nxt = m_st;
      if (m_st == 0) begin
        if (p_ss) nxt = 1;
      end else if (m_st == 1) begin
        if (int'(sec_count_in) >= MAXC) nxt = 3;
        else if (p_ss) nxt = 2;
        if (LAP_EN && p_lap) begin m_lap = int'(sec_count_in); m_lv = 1; end
      end else if (m_st == 2) begin
        if (p_clr) nxt = 0;
        else if (p_ss) nxt = 1;
      end else if (p_clr) nxt = 0;
      if (nxt == 0 && m_st != 0) begin m_lap = 0; m_lv = 0; end
      m_st = nxt;
    end
  always @(negedge clk)
    if (hard_reset) begin
      check("state", 32'(state), 32'(m_st));
      check("en", 32'(en), m_st == 0 ? 0 : m_st == 1 ? 1 : 2);
      check("overflow", 32'(overflow), 32'(m_st == 3));
      check("lap_count", 32'(lap_count), 32'(m_lap));
      check("lap_valid", 32'(lap_valid), 32'(m_lv));
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int which, input int hold);
    if (which == 0) btn_start_stop = 1'b1;
    else if (which == 1) btn_clear = 1'b1;
    else btn_lap = 1'b1;
    cyc(hold);
    btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    cyc(4);
  endtask
  initial begin
    #2;
    check("rst_en", 32'(en), 0);
    check("rst_state", 32'(state), 0);
    check("rst_lap", 32'(lap_count), 0);
    cyc(2);
    hard_reset = 1'b1;
    cyc(3);
    btn_start_stop = 1'b1;
    cyc(1); check("lat_n", 32'(en), 0);
    cyc(1); check("lat_n1", 32'(en), 0);
    cyc(1); check("lat_n2", 32'(en), 1);
    btn_start_stop = 1'b0;
    cyc(4);
    press(0, 1); check("pause", 32'(en), 2);
    press(0, 1); check("resume", 32'(en), 1);
    press(0, 50); check("held_once", 32'(en), 2);
    press(0, 1); check("run_again", 32'(en), 1);
    press(1, 1); check("clr_in_run", 32'(en), 1);
    sec_count_in = 42;
    press(2, 1);
    check("lap42", 32'(lap_count), LAP_EN ? 42 : 0);
    check("lap_valid", 32'(lap_valid), 32'(LAP_EN));
    sec_count_in = 100;
    press(0, 1); check("pause2", 32'(en), 2);
    press(2, 1); check("lap_in_pause", 32'(lap_count), LAP_EN ? 42 : 0);
    press(0, 1); check("run3", 32'(en), 1);
    sec_count_in = 19'(MAXC);
    cyc(1);
    check("ovf_state", 32'(state), 3);
    check("ovf_en", 32'(en), 2);
    check("ovf_flag", 32'(overflow), 1);
    sec_count_in = 0;
    press(0, 1); check("ovf_ss_ign", 32'(state), 3);
    press(2, 1); check("ovf_lap_ign", 32'(lap_count), LAP_EN ? 42 : 0);
    press(1, 1);
    check("ovf_clr_en", 32'(en), 0);
    check("ovf_clr_flag", 32'(overflow), 0);
    check("ovf_clr_lv", 32'(lap_valid), 0);
    press(1, 1); check("clr_in_clear", 32'(state), 0);
    press(2, 1); check("lap_in_clear", 32'(lap_valid), 0);
    sec_count_in = 5;
    press(0, 1); press(0, 1); check("pause3", 32'(state), 2);
    btn_start_stop = 1'b1; btn_clear = 1'b1;
    cyc(1);
    btn_start_stop = 1'b0; btn_clear = 1'b0;
    cyc(4);
    check("both_state", 32'(state), 0);
    check("both_en", 32'(en), 0);
    sec_count_in = 7;
    press(0, 1); check("run4", 32'(en), 1);
    btn_start_stop = 1'b1; btn_lap = 1'b1;
    @(posedge clk); #2;
    hard_reset = 1'b0;
    #1;
    check("async_en", 32'(en), 0);
    check("async_state", 32'(state), 0);
    check("async_lap", 32'(lap_valid), 0);
    cyc(2);
    hard_reset = 1'b1;
    cyc(5); check("post_rst_run", 32'(en), 1);
    check("post_rst_nolap", 32'(lap_valid), 0);
    cyc(10); check("post_rst_once", 32'(en), 1);
    btn_start_stop = 1'b0; btn_lap = 1'b0;
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
